// File: rtl/cart_pkg.sv
// Shared definitions for the cartridge memory port: FSM states,
// default address width and the open-bus read value.
package cart_pkg;

    localparam int         CART_AW  = 25;
    localparam logic [7:0] OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } cart_state_t;

endpackage

// File: rtl/cart_mem_cache1.sv
// One-entry read cache: tag/data/valid with full-width hit compare.
// Fill has priority over invalidate, which has priority over a write update.
module cart_mem_cache1
    import cart_pkg::*;
#(
    parameter int AW = CART_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] lookup_addr,
    output logic          hit,
    output logic [7:0]    rd_data,
    input  logic          upd_en,
    input  logic [7:0]    upd_data,
    input  logic          fill_en,
    input  logic [AW-1:0] fill_tag,
    input  logic [7:0]    fill_data,
    input  logic          inv_en
);

    logic [AW-1:0] tag_r;
    logic [7:0]    data_r;
    logic          valid_r;

    assign hit     = valid_r & (lookup_addr == tag_r);
    assign rd_data = data_r;

    // Cache entry storage: fill from memory, invalidate, or write-through update on hit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_r   <= '0;
            data_r  <= 8'h00;
            valid_r <= 1'b0;
        end else if (fill_en) begin
            tag_r   <= fill_tag;
            data_r  <= fill_data;
            valid_r <= 1'b1;
        end else if (inv_en) begin
            valid_r <= 1'b0;
        end else if (upd_en & hit) begin
            data_r  <= upd_data;
        end
    end

endmodule

// File: rtl/cart_mem_port.sv
// Cartridge request responder: turns level-style cart reads/writes into
// req/ack memory transactions, serves repeated reads from a one-entry
// cache and abandons a transaction after TIMEOUT cycles without ack.
module cart_mem_port
    import cart_pkg::*;
#(
    parameter int AW      = CART_AW,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] ram_addr,
    input  logic [7:0]    ram_din,
    input  logic          ram_we,
    input  logic          ram_rd,
    output logic [7:0]    ram_dout,
    output logic          ram_ready,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    output logic          mem_req,
    input  logic          mem_ack,
    input  logic [7:0]    mem_dout,
    output logic          timeout_err
);

    // Last counter value before the transaction is abandoned.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    cart_state_t state_r, state_nx_s;
    logic [15:0] tmo_cnt_r;
    logic        hit_s, miss_s, busy_s, tmo_last_s;
    logic [7:0]  cache_data_s;
    logic        start_wr_s, start_rd_s, hit_rd_s;
    logic        done_s, abort_s, fill_s, inv_s;

    assign miss_s     = ~hit_s;
    assign busy_s     = (state_r != ST_IDLE);
    assign tmo_last_s = (tmo_cnt_r == TMO_LAST);
    assign ram_ready  = (state_r == ST_IDLE) & ~ram_we & ~(ram_rd & miss_s);

    cart_mem_cache1 #(.AW(AW)) u_cache (
        .clk         (clk),
        .reset_n     (reset_n),
        .lookup_addr (ram_addr),
        .hit         (hit_s),
        .rd_data     (cache_data_s),
        .upd_en      (start_wr_s),
        .upd_data    (ram_din),
        .fill_en     (fill_s),
        .fill_tag    (mem_addr),
        .fill_data   (mem_dout),
        .inv_en      (inv_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next state: writes win over reads; ack wins over timeout
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ram_we) begin
                    state_nx_s = ST_WR;
                end else if (ram_rd & miss_s) begin
                    state_nx_s = ST_RD;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RD, ST_WR: begin
                if (mem_ack | tmo_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = state_r;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath and cache
    always_comb begin
        start_wr_s = 1'b0;
        start_rd_s = 1'b0;
        hit_rd_s   = 1'b0;
        done_s     = 1'b0;
        abort_s    = 1'b0;
        fill_s     = 1'b0;
        inv_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ram_we) begin
                    start_wr_s = 1'b1;
                end else if (ram_rd & miss_s) begin
                    start_rd_s = 1'b1;
                end else if (ram_rd) begin
                    hit_rd_s = 1'b1;
                end else begin
                    hit_rd_s = 1'b0;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    done_s = 1'b1;
                    fill_s = 1'b1;
                end else if (tmo_last_s) begin
                    abort_s = 1'b1;
                    inv_s   = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            ST_WR: begin
                if (mem_ack) begin
                    done_s = 1'b1;
                end else if (tmo_last_s) begin
                    abort_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            default: done_s = 1'b0;
        endcase
    end

    // Registered memory request, read data, timeout counter and sticky error.
    // ram_dout tracks cache data on every cache change so a hit is valid immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= 8'h00;
            ram_dout    <= OPEN_BUS;
            tmo_cnt_r   <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            if (start_wr_s) begin
                mem_addr <= ram_addr;
                mem_din  <= ram_din;
                mem_we   <= 1'b1;
                mem_req  <= 1'b1;
            end else if (start_rd_s) begin
                mem_addr <= ram_addr;
                mem_we   <= 1'b0;
                mem_req  <= 1'b1;
            end else if (done_s | abort_s) begin
                mem_req  <= 1'b0;
            end

            if (fill_s) begin
                ram_dout <= mem_dout;
            end else if (inv_s) begin
                ram_dout <= OPEN_BUS;
            end else if (start_wr_s & hit_s) begin
                ram_dout <= ram_din;
            end else if (hit_rd_s) begin
                ram_dout <= cache_data_s;
            end

            if (start_wr_s | start_rd_s) begin
                tmo_cnt_r <= 16'd0;
            end else if (busy_s & ~mem_ack) begin
                tmo_cnt_r <= tmo_cnt_r + 16'd1;
            end

            if (abort_s) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cart_mem_port.sv
// Bench for cart_mem_port: table of directed transactions, hand-written
// write/read collision, timeout and reset sequences, then random traffic
// checked against a cache/memory model kept in the bench.
module tb_cart_mem_port;

    localparam int AW  = 25;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic          ram_rd;
    logic [7:0]    ram_dout;
    logic          ram_ready;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic          mem_req;
    logic          mem_ack;
    logic [7:0]    mem_dout;
    logic          timeout_err;

    cart_mem_port #(.AW(AW), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_rd      (ram_rd),
        .ram_dout    (ram_dout),
        .ram_ready   (ram_ready),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_dout    (mem_dout),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // External memory contents (written only through DUT transactions)
    logic [7:0] ext_mem [logic [AW-1:0]];
    // Bench's own record of what was intentionally written
    logic [7:0] ref_mem [logic [AW-1:0]];

    int lat = 1;
    bit mute = 1'b0;
    bit stray = 1'b0;
    int req_cyc = 0;
    int rd_starts = 0;
    int wr_starts = 0;
    bit txn_q [$];

    // Reference cache model
    bit            m_valid;
    logic [AW-1:0] m_tag;
    logic [7:0]    m_data;

    function automatic logic [7:0] dflt(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_val(input logic [AW-1:0] a);
        if (ext_mem.exists(a)) return ext_mem[a];
        return dflt(a);
    endfunction

    function automatic logic [7:0] ref_val(input logic [AW-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory responder: ack in the lat-th cycle of a request unless muted
    initial begin
        mem_ack  = 1'b0;
        mem_dout = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (!mem_req) begin
                req_cyc = 0;
                if (stray) begin
                    mem_ack  = 1'b1;
                    mem_dout = 8'h00;
                    stray    = 1'b0;
                end
            end else begin
                req_cyc++;
                if (req_cyc == 1) begin
                    if (mem_we) wr_starts++;
                    else        rd_starts++;
                    txn_q.push_back(mem_we);
                end
                if (!mute && req_cyc == lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) ext_mem[mem_addr] = mem_din;
                    else        mem_dout = mem_val(mem_addr);
                end
            end
        end
    end

    task automatic do_read(input logic [AW-1:0] a, input int l, input logic [7:0] exp,
                           input int exp_reqs, input string nm);
        int s0;
        int cyc;
        s0 = rd_starts + wr_starts;
        lat = l;
        mute = 1'b0;
        ram_addr = a;
        ram_we = 1'b0;
        ram_rd = 1'b1;
        #1;
        cyc = 0;
        while (!ram_ready && cyc < 40) begin
            tick();
            cyc++;
        end
        chk($sformatf("%s ready", nm), 32'(ram_ready), 32'd1);
        chk($sformatf("%s data", nm), 32'(ram_dout), 32'(exp));
        chk($sformatf("%s reqs", nm), rd_starts + wr_starts - s0, exp_reqs);
        chk($sformatf("%s latency", nm), cyc, (exp_reqs == 0) ? 0 : l + 1);
        tick();
        ram_rd = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d, input int l,
                            input string nm);
        int s0;
        int cyc;
        s0 = wr_starts;
        lat = l;
        mute = 1'b0;
        ram_addr = a;
        ram_din = d;
        ram_rd = 1'b0;
        ram_we = 1'b1;
        tick();
        ram_we = 1'b0;
        chk($sformatf("%s mem_we", nm), 32'(mem_we), 32'd1);
        chk($sformatf("%s mem_addr", nm), 32'(mem_addr), 32'(a));
        chk($sformatf("%s mem_din", nm), 32'(mem_din), 32'(d));
        cyc = 0;
        while (mem_req && cyc < 40) begin
            tick();
            cyc++;
        end
        chk($sformatf("%s req cycles", nm), cyc, l);
        chk($sformatf("%s writes", nm), wr_starts - s0, 1);
        chk($sformatf("%s memory", nm), 32'(mem_val(a)), 32'(d));
        ref_mem[a] = d;
    endtask

    typedef struct packed {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [7:0]    data;   // write data, or expected read data
        logic [7:0]    lat;
        logic [1:0]    reqs;   // expected memory transactions for a read
    } vec_t;

    vec_t tbl [9];
    logic [AW-1:0] pool [6];

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int cyc;
        logic [AW-1:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        int l;
        bit hit;

        tbl[0] = '{1'b0, 25'h0004000, 8'h3C, 8'd3, 2'd1};
        tbl[1] = '{1'b0, 25'h0004000, 8'h3C, 8'd1, 2'd0};
        tbl[2] = '{1'b0, 25'h0004001, 8'h5B, 8'd2, 2'd1};
        tbl[3] = '{1'b0, 25'h0004000, 8'h3C, 8'd1, 2'd1};
        tbl[4] = '{1'b1, 25'h0004000, 8'h55, 8'd2, 2'd1};
        tbl[5] = '{1'b0, 25'h0004000, 8'h55, 8'd1, 2'd0};
        tbl[6] = '{1'b1, 25'h0008000, 8'hAA, 8'd4, 2'd1};
        tbl[7] = '{1'b0, 25'h0004000, 8'h55, 8'd1, 2'd0};
        tbl[8] = '{1'b0, 25'h0008000, 8'hAA, 8'd8, 2'd1};

        pool[0] = 25'h0004000;
        pool[1] = 25'h0004001;
        pool[2] = 25'h0008000;
        pool[3] = 25'h1FFFFFF;
        pool[4] = 25'h0FFFFFF;
        pool[5] = 25'h0000000;

        ext_mem[25'h0004000] = 8'h3C;
        ref_mem[25'h0004000] = 8'h3C;

        reset_n  = 1'b0;
        ram_addr = '0;
        ram_din  = 8'h00;
        ram_we   = 1'b0;
        ram_rd   = 1'b0;
        #12;
        chk("reset ram_dout", 32'(ram_dout), 32'hFF);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_din", 32'(mem_din), 32'd0);
        chk("reset timeout_err", 32'(timeout_err), 32'd0);
        chk("reset ram_ready", 32'(ram_ready), 32'd1);
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].is_wr) begin
                do_write(tbl[i].addr, tbl[i].data, int'(tbl[i].lat), $sformatf("vec%0d", i));
            end else begin
                do_read(tbl[i].addr, int'(tbl[i].lat), tbl[i].data, int'(tbl[i].reqs),
                        $sformatf("vec%0d", i));
            end
        end
        chk("ack on last cycle keeps err clear", 32'(timeout_err), 32'd0);

        // Stray ack while idle must be ignored
        stray = 1'b1;
        tick();
        tick();
        chk("stray ack ram_dout", 32'(ram_dout), 32'hAA);
        chk("stray ack mem_req", 32'(mem_req), 32'd0);
        chk("stray ack ready", 32'(ram_ready), 32'd1);

        // Write and read miss presented together: write first, then read
        s0 = rd_starts + wr_starts;
        lat = 2;
        ram_addr = 25'h0010000;
        ram_din = 8'h77;
        ram_we = 1'b1;
        ram_rd = 1'b1;
        tick();
        ram_we = 1'b0;
        cyc = 0;
        while (!ram_ready && cyc < 60) begin
            tick();
            cyc++;
        end
        ref_mem[25'h0010000] = 8'h77;
        chk("we+rd ready", 32'(ram_ready), 32'd1);
        chk("we+rd data", 32'(ram_dout), 32'h77);
        chk("we+rd txn count", rd_starts + wr_starts - s0, 2);
        chk("we+rd first is write", (txn_q.size() >= 2) ? 32'(txn_q[txn_q.size() - 2]) : 32'd9, 32'd1);
        chk("we+rd second is read", 32'(txn_q[txn_q.size() - 1]), 32'd0);
        ram_rd = 1'b0;
        tick();

        // Read with no ack: abandoned after TMO cycles
        mute = 1'b1;
        ram_addr = 25'h0020000;
        ram_rd = 1'b1;
        tick();
        ram_rd = 1'b0;
        cyc = 0;
        while (mem_req && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("timeout req cycles", cyc, TMO);
        chk("timeout ram_dout", 32'(ram_dout), 32'hFF);
        chk("timeout err", 32'(timeout_err), 32'd1);
        chk("timeout ready", 32'(ram_ready), 32'd1);
        mute = 1'b0;
        do_read(25'h0020000, 2, 8'h5A, 1, "after timeout");
        chk("timeout err sticky", 32'(timeout_err), 32'd1);

        // Reset in the middle of a read
        mute = 1'b1;
        ram_addr = 25'h0030000;
        ram_rd = 1'b1;
        tick();
        tick();
        chk("pre-reset mem_req", 32'(mem_req), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async reset mem_req", 32'(mem_req), 32'd0);
        chk("async reset ram_dout", 32'(ram_dout), 32'hFF);
        chk("async reset err", 32'(timeout_err), 32'd0);
        ram_rd = 1'b0;
        mute = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        do_read(25'h0020000, 3, 8'h5A, 1, "after reset");

        // Random traffic against the model
        m_valid = 1'b1;
        m_tag   = 25'h0020000;
        m_data  = 8'h5A;
        for (int i = 0; i < 40; i++) begin
            a = pool[$urandom_range(0, 5)];
            l = int'($urandom_range(1, 5));
            if ($urandom_range(0, 9) < 3) begin
                d = 8'($urandom);
                do_write(a, d, l, $sformatf("rnd%0d wr", i));
                if (m_valid && m_tag == a) m_data = d;
            end else begin
                hit = m_valid && (m_tag == a);
                exp = hit ? m_data : ref_val(a);
                do_read(a, l, exp, hit ? 0 : 1, $sformatf("rnd%0d rd", i));
                m_valid = 1'b1;
                m_tag   = a;
                m_data  = exp;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cart_mem_port.md
Name: cart_mem_port

Overview:
- Memory-side responder for the cartridge ROM/mapper request interface (ram_addr/ram_rd/ram_we/ram_din in, ram_dout/ram_ready out).
- Converts level-style cart requests into a req/ack transaction on the shared external memory (SDRAM arbiter port).
- Holds a one-entry read cache so repeated CPU fetches at the same address do not re-issue memory cycles.
- Guards against a hung memory with a timeout that returns 8'hFF and sets a sticky error flag.

Parameters:
AW, 25, cart/memory byte address width
TIMEOUT, 255, max cycles waiting for mem_ack before abandoning a transaction (1..65535)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ram_addr  in  AW  cart request byte address
ram_din  in  8  cart write data
ram_we  in  1  write request (level; a high sample starts one write)
ram_rd  in  1  read request (level; held while slot selected)
ram_dout  out  8  read data to cart
ram_ready  out  1  1 = no transaction outstanding, ram_dout valid for current ram_addr
mem_addr  out  AW  memory address
mem_din  out  8  memory write data
mem_we  out  1  1 = write transaction, 0 = read
mem_req  out  1  request, held until ack or timeout
mem_ack  in  1  one-cycle completion pulse from memory
mem_dout  in  8  memory read data, valid in the mem_ack cycle
timeout_err  out  1  sticky, set on any timeout

Behaviour:
- States: IDLE, RD, WR. Cache: tag[AW-1:0], data[7:0], valid.
- Reset values: state=IDLE, valid=0, tag=0, ram_dout=8'hFF, mem_req=0, mem_we=0, mem_addr=0, mem_din=0, timeout_err=0, timeout counter=0.
- miss = ~valid | (ram_addr != tag).
- ram_ready (combinational) = (state==IDLE) & ~ram_we & ~(ram_rd & miss).
- IDLE, ram_we=1 (priority over ram_rd):
  - Latch mem_addr=ram_addr, mem_din=ram_din, mem_we=1, mem_req=1; go to WR.
  - If valid & ram_addr==tag, update cache data to ram_din in the same cycle.
- IDLE, ram_we=0, ram_rd=1, miss: latch mem_addr=ram_addr, mem_we=0, mem_req=1; go to RD.
- IDLE, ram_rd=1, hit: no memory cycle. ram_dout=cache data, zero latency.
- RD:
  - On mem_ack: tag=mem_addr, data=mem_dout, valid=1, ram_dout=mem_dout, mem_req=0; go to IDLE.
  - ram_ready rises in the following cycle if ram_addr still equals tag.
  - Read latency = memory latency + 1 cycle.
- WR: on mem_ack, mem_req=0 and go to IDLE. A write to a non-cached address leaves the cache untouched.
- Outstanding transactions:
  - ram_addr, ram_we and ram_rd changes are ignored while in RD or WR.
  - A changed address is handled as a new miss after the return to IDLE.
  - At most one outstanding transaction.
- Timeout:
  - Counter clears on entry to RD/WR and increments each cycle without mem_ack.
  - When it reaches TIMEOUT: mem_req=0, timeout_err=1, return to IDLE.
  - For RD, additionally ram_dout=8'hFF and valid=0 (no cache fill).
  - An ack in the same cycle as the timeout wins (normal completion).
- mem_ack while in IDLE is ignored.
- mem_req never deasserts without ack or timeout. mem_addr/mem_din/mem_we stay stable while mem_req=1.
- reset_n low mid-transaction drops mem_req immediately (asynchronous). The memory side tolerates an abandoned request.
- Address compare is full AW width, with no masking.

Decomposition:
- Shared package cart_pkg: state enum (IDLE/RD/WR), AW default constant, 8'hFF open-bus constant.
- One natural sub-module: cart_mem_cache1 (tag/data/valid register plus hit compare, with write-update and invalidate ports).
- The FSM and timeout counter stay in cart_mem_port.

Test Plan:
- Read miss: ram_rd=1, ram_addr=0x0004000, mem_dout=0x3C with ack 3 cycles after req → mem_req for 3 cycles, ram_dout=0x3C, ram_ready=1 one cycle after ack.
- Read hit: same address held or re-presented → no mem_req, ram_ready=1 combinationally, ram_dout=0x3C. Then address 0x0004001 → new miss issued.
- Write hit/miss:
  - Write 0x55 to 0x0004000 (cached) → mem_we=1 cycle issued; the next read returns 0x55 without mem_req.
  - Write to 0x0008000 → cache unchanged.
- Simultaneous ram_we=1 and ram_rd=1 miss at the same address → write is issued first; the read is issued after the write ack.
- Timeout: TIMEOUT=8, no ack on read → mem_req drops after 8 cycles, ram_dout=8'hFF, timeout_err=1 (sticky), valid=0. Ack arriving exactly at the 8th cycle → normal completion, err stays 0.
- Reset mid-RD: assert reset_n=0 while mem_req=1 → mem_req=0, ram_dout=8'hFF, valid=0 asynchronously. After release, the first read misses.
